// File: rtl/pwm_multi_core_pkg.sv
// Shared definitions for the multi-channel PWM core: duty constants,
// counting-mode encoding and the period lookup used to build the period table.
package pwm_multi_core_pkg;

  localparam int DUTY_W   = 7;
  localparam int DUTY_MAX = 100;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  // Period in clocks for frequency code {pow5, pow2}; multiplier is 2^pow2 * 5^pow5.
  function automatic int unsigned period_lookup(input int unsigned clk_freq,
                                                input int unsigned base_hz,
                                                input logic [3:0]  code);
    int unsigned mult;
    case (code)
      4'd0:    mult = 32'd1;
      4'd1:    mult = 32'd2;
      4'd2:    mult = 32'd4;
      4'd3:    mult = 32'd8;
      4'd4:    mult = 32'd5;
      4'd5:    mult = 32'd10;
      4'd6:    mult = 32'd20;
      4'd7:    mult = 32'd40;
      4'd8:    mult = 32'd25;
      4'd9:    mult = 32'd50;
      4'd10:   mult = 32'd100;
      4'd11:   mult = 32'd200;
      4'd12:   mult = 32'd125;
      4'd13:   mult = 32'd250;
      4'd14:   mult = 32'd500;
      default: mult = 32'd1000;
    endcase
    return clk_freq / (base_hz * mult);
  endfunction

endpackage

// File: rtl/pwm_multi_core_channel.sv
// One PWM channel: duty/polarity shadow captured as a compare threshold at the
// period boundary, compared against the shared counter into a registered output.
module pwm_multi_core_channel
  import pwm_multi_core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              load,
  input  logic              mode_next,
  input  logic [CNT_W-1:0]  per_next,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              pol_in,
  input  logic              mode_sh,
  input  logic [CNT_W-1:0]  cnt,
  output logic              pwm
);

  localparam int PW = CNT_W + DUTY_W;

  logic [DUTY_W-1:0] duty_s;
  logic [CNT_W-1:0]  base_s;
  logic [CNT_W-1:0]  share_s;
  logic [CNT_W-1:0]  thr_s;
  logic [PW-1:0]     prod_s;
  logic [CNT_W-1:0]  thr_r;
  logic              pol_r;
  logic              pwm_r;
  logic              raw_s;

  // Threshold for the upcoming period; centre mode stores H-Ch so one >= compare covers both directions.
  always_comb begin
    duty_s  = (duty_in > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : duty_in;
    base_s  = (mode_next == MODE_CENTER) ? (per_next >> 1) : per_next;
    prod_s  = (PW'(base_s) * PW'(duty_s)) / PW'(DUTY_MAX);
    share_s = prod_s[CNT_W-1:0];
    thr_s   = (mode_next == MODE_CENTER) ? (base_s - share_s) : share_s;
    raw_s   = (mode_sh == MODE_CENTER) ? (cnt >= thr_r) : (cnt < thr_r);
  end

  // Shadow registers and the registered, polarity-adjusted output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      thr_r <= {CNT_W{1'b0}};
      pol_r <= 1'b0;
      pwm_r <= 1'b0;
    end else begin
      if (load) begin
        thr_r <= thr_s;
        pol_r <= pol_in;
      end
      pwm_r <= en ? (raw_s ^ pol_r) : pol_r;
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/pwm_multi_core.sv
// Multi-channel PWM core: shared edge/centre period counter, boundary-synchronous
// configuration shadowing, period_start pulse and completed-period counter.
module pwm_multi_core
  import pwm_multi_core_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BASE_HZ  = 1000,
  parameter int          N_CH     = 4,
  parameter int          CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   mode_center,
  input  logic [1:0]             pow2,
  input  logic [1:0]             pow5,
  input  logic [DUTY_W*N_CH-1:0] duty_percent_in,
  input  logic [N_CH-1:0]        ch_pol,
  output logic [N_CH-1:0]        pwm_out,
  output logic                   period_start,
  output logic [CNT_W-1:0]       period_count
);

  localparam int unsigned P_MIN = period_lookup(CLK_FREQ, BASE_HZ, 4'hF);

  if (P_MIN < 32'd4) begin : g_bad_period
    $error("pwm_multi_core: shortest period below 4 clocks");
  end
  if ((N_CH < 1) || (N_CH > 16)) begin : g_bad_nch
    $error("pwm_multi_core: N_CH out of range");
  end

  logic [CNT_W-1:0] per_tab [16];

  for (genvar g = 0; g < 16; g++) begin : g_tab
    localparam int unsigned PV = period_lookup(CLK_FREQ, BASE_HZ, 4'(g));
    assign per_tab[g] = CNT_W'(PV);
  end

  logic [CNT_W-1:0] per_next_s;
  logic [CNT_W-1:0] half_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             dir_nxt_s;
  logic             last_s;
  logic             turn_s;
  logic             load_s;
  pwm_mode_e        mode_nxt_s;

  logic [CNT_W-1:0] cnt_r;
  logic             dir_down_r;
  pwm_mode_e        mode_sh_r;
  logic [CNT_W-1:0] per_sh_r;
  logic             period_start_r;
  logic [CNT_W-1:0] period_count_r;

  // Boundary detect and counter next-state; >= compares keep a zero period from locking up.
  always_comb begin
    per_next_s = per_tab[{pow5, pow2}];
    mode_nxt_s = pwm_mode_e'(mode_center);
    half_s     = per_sh_r >> 1;
    turn_s     = (({1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, half_s});
    cnt_nxt_s  = cnt_r;
    dir_nxt_s  = dir_down_r;
    if (mode_sh_r == MODE_EDGE) begin
      last_s = en && (({1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, per_sh_r});
    end else begin
      last_s = en && dir_down_r && (cnt_r == {CNT_W{1'b0}});
    end
    load_s = !en || last_s;
    if (load_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      dir_nxt_s = 1'b0;
    end else if (mode_sh_r == MODE_EDGE) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!dir_down_r) begin
      if (turn_s) begin
        dir_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter, shared shadows and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r          <= {CNT_W{1'b0}};
      dir_down_r     <= 1'b0;
      mode_sh_r      <= MODE_EDGE;
      per_sh_r       <= {CNT_W{1'b0}};
      period_start_r <= 1'b0;
      period_count_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r          <= cnt_nxt_s;
      dir_down_r     <= dir_nxt_s;
      period_start_r <= en && (cnt_r == {CNT_W{1'b0}}) && !dir_down_r;
      if (load_s) begin
        mode_sh_r <= mode_nxt_s;
        per_sh_r  <= per_next_s;
      end
      if (last_s) begin
        period_count_r <= period_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_multi_core_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .load      (load_s),
      .mode_next (mode_nxt_s),
      .per_next  (per_next_s),
      .duty_in   (duty_percent_in[DUTY_W*k +: DUTY_W]),
      .pol_in    (ch_pol[k]),
      .mode_sh   (mode_sh_r),
      .cnt       (cnt_r),
      .pwm       (pwm_out[k])
    );
  end

  assign period_start = period_start_r;
  assign period_count = period_count_r;

endmodule

// File: tb/tb_pwm_multi_core.sv
// Directed bench for pwm_multi_core: expected per-cycle waveforms are queued as
// stimulus is applied and compared on each falling edge.
module tb_pwm_multi_core;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b0;
  logic        mode_center = 1'b0;
  logic [1:0]  pow2 = 2'd3;
  logic [1:0]  pow5 = 2'd3;
  logic [27:0] duty_percent_in = {7'd127, 7'd100, 7'd0, 7'd30};
  logic [3:0]  ch_pol = 4'b0000;
  logic [3:0]  pwm_out;
  logic        period_start;
  logic [31:0] period_count;

  pwm_multi_core dut (
    .clk             (clk),
    .rstn            (rstn),
    .en              (en),
    .mode_center     (mode_center),
    .pow2            (pow2),
    .pow5            (pow5),
    .duty_percent_in (duty_percent_in),
    .ch_pol          (ch_pol),
    .pwm_out         (pwm_out),
    .period_start    (period_start),
    .period_count    (period_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pwm;
    logic       ps;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // ch0 is high for period positions [h_from, h_to) before polarity; ch1=0, ch2/ch3 always 1
  task automatic push_period(input int p, input int h_from, input int h_to, input logic pol0);
    exp_t e;
    for (int i = 0; i < p; i++) begin
      e.pwm = {3'b110, ((i >= h_from) && (i < h_to)) ^ pol0};
      e.ps  = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_one(input logic [3:0] pw, input logic ps);
    exp_t e;
    e.pwm = pw;
    e.ps  = ps;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_underrun: observed empty scoreboard expected an entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("pwm_out", 32'(pwm_out), 32'(e.pwm));
        chk("period_start", 32'(period_start), 32'(e.ps));
      end
    end
  endtask

  initial begin
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("reset_pwm", 32'(pwm_out), 32'd0);
    chk("reset_ps", 32'(period_start), 32'd0);
    chk("reset_pc", period_count, 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pwm", 32'(pwm_out), 32'd0);
    chk("idle_pc", period_count, 32'd0);

    // Edge mode P=50: ch0 30% -> 15 high; ch1 0%, ch2 100%, ch3 127 clamped
    en = 1'b1;
    for (int k = 0; k < 4; k++) push_period(50, 0, 15, 1'b0);
    step(200);
    chk("pc_after_4", period_count, 32'd4);

    // Mode change mid-period only applies at the next boundary; centre: 14 high at [18,32)
    push_period(50, 0, 15, 1'b0);
    step(20);
    mode_center = 1'b1;
    step(30);
    push_period(50, 18, 32, 1'b0);
    push_period(50, 18, 32, 1'b0);
    step(100);

    // Back to edge, then duty 50 and pow5=2 at position 20 -> next period P=250, 125 high
    mode_center = 1'b0;
    push_period(50, 18, 32, 1'b0);
    push_period(50, 0, 15, 1'b0);
    step(70);
    duty_percent_in[6:0] = 7'd50;
    pow5 = 2'd2;
    push_period(250, 0, 125, 1'b0);
    step(280);
    chk("pc_after_p250", period_count, 32'd10);

    // en=0 with inverted ch0: one cycle on old polarity, then inactive level 1
    en = 1'b0;
    ch_pol = 4'b0001;
    duty_percent_in[6:0] = 7'd30;
    pow5 = 2'd3;
    push_one(4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) push_one(4'b0001, 1'b0);
    step(4);
    chk("pc_held", period_count, 32'd10);
    en = 1'b1;
    push_period(50, 0, 15, 1'b1);
    step(50);
    chk("pc_after_inv", period_count, 32'd11);

    // Reset asserted while cnt=17
    push_period(50, 0, 15, 1'b1);
    step(17);
    rstn = 1'b0;
    en = 1'b0;
    ch_pol = 4'b0000;
    exp_q.delete();
    #1;
    chk("async_pwm", 32'(pwm_out), 32'd0);
    chk("async_ps", 32'(period_start), 32'd0);
    chk("async_pc", period_count, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_pwm", 32'(pwm_out), 32'd0);
    end
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_pwm", 32'(pwm_out), 32'd0);
      chk("post_rst_ps", 32'(period_start), 32'd0);
      chk("post_rst_pc", period_count, 32'd0);
    end
    en = 1'b1;
    push_period(50, 0, 15, 1'b0);
    step(50);
    chk("pc_after_rst", period_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_multi_core.md
Name: pwm_multi_core

Overview:
Multi-channel PWM generator and successor of the single-channel duty/pow2/pow5 core. One shared period counter, selected by the pow2/pow5 frequency code, drives N_CH channels. Each channel has its own duty percent and output polarity. All configuration is double-buffered and applied only at period boundaries, so outputs never glitch. An edge-aligned or a centre-aligned counting mode is selectable, and a completed-period counter feeds the UART status path.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz
BASE_HZ, 1000, PWM frequency for pow2=0, pow5=0
N_CH, 4, number of PWM channels (1..16)
CNT_W, 32, width of the period counter and of period_count

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
en  in  1  global enable
mode_center  in  1  0 = edge-aligned, 1 = centre-aligned
pow2  in  2  frequency multiplier exponent of 2 (0..3)
pow5  in  2  frequency multiplier exponent of 5 (0..3)
duty_percent_in  in  7*N_CH  per-channel duty in percent; channel k uses bits [7k+6:7k]
ch_pol  in  N_CH  per-channel polarity; 1 = inverted output
pwm_out  out  N_CH  PWM outputs
period_start  out  1  one-cycle pulse in the first cycle of every period
period_count  out  CNT_W  number of completed periods, wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous and active-low, exactly as decided for this block: one clock, clk; reset port rstn.
- Reset values:
  - counter, period_count and period_start = 0
  - pwm_out = 0
  - all shadow registers = 0
- Period length: P = floor(CLK_FREQ / (BASE_HZ * 2^pow2 * 5^pow5)).
  - Defaults give P = 50 (pow2=3, pow5=3) up to P = 50000 (pow2=0, pow5=0).
  - Elaboration fails if the smallest P < 4.
- Shadowing:
  - mode, P, per-channel duty and per-channel polarity are copied into shadow registers on the last cycle of a period.
  - While en=0 the shadows load on every cycle instead.
  - Changing any input mid-period has no effect until the next period.
- Duty clamp: d = min(duty_percent_in[k], 100).
- Edge mode:
  - counter runs 0..P-1, then wraps to 0.
  - C = floor(P*d/100); raw = (cnt < C).
  - The last cycle of the period is cnt == P-1.
- Centre mode:
  - H = floor(P/2); the counter counts up 0..H-1, then down H-1..0, giving a period of 2H cycles.
  - Ch = floor(H*d/100); raw = (cnt >= H-Ch) in both directions.
  - This gives 2*Ch high cycles, symmetric about the turnaround.
  - The last cycle of the period is cnt == 0 during the down phase.
- Output:
  - pwm_out[k] = raw ^ pol_shadow[k], registered, so there is 1 cycle of latency from the counter.
  - d=0 gives a constant inactive level; d>=100 gives a constant active level with no single-cycle gaps.
- period_start: high while the registered outputs show the first cycle of a period, including the first period after en rises.
- period_count: increments by 1 on each completed period and wraps from 2^CNT_W-1 to 0.
- en=0:
  - counter held at 0, up/down direction reset to "up".
  - pwm_out = pol_shadow (inactive level); period_start = 0.
  - period_count is held, not cleared.
- en rising: the first period starts on the next cycle, using the shadows loaded in the en=0 cycle.
- Mode switch: takes effect at the boundary only; the direction flag resets to "up".
- Reset asserted mid-period: all outputs go to their reset values immediately (asynchronously).

Decomposition:
- Shared header pwm_defs.vh holds:
  - DUTY_W = 7 and DUTY_MAX = 100
  - a period-lookup function computing P from pow2/pow5, CLK_FREQ and BASE_HZ (16-entry constant table)
  - mode encodings
- Sub-module pwm_channel holds the per-channel logic (duty/polarity shadow, compare value, registered output). It is instantiated N_CH times by a generate loop.
- The top level owns the counter, direction flag, boundary detect, period_start and period_count.

Test Plan:
1. Edge mode, pow2=3, pow5=3, duty ch0=30, en=1 -> P=50; ch0 high for 15 cycles and low for 35; period_start every 50 cycles; period_count=4 after 200 cycles.
2. Duty clamp and extremes: ch1=0, ch2=100, ch3=127 -> ch1 constant 0; ch2 and ch3 constant 1 across 3 periods with no single-cycle gaps.
3. Centre mode, P=50 (H=25), ch0 duty 30 -> Ch=7; ch0 high for 14 consecutive cycles centred on the turnaround; period is 50 cycles.
4. Glitch-free update: change ch0 duty 30->50 and pow5 3->2 at cycle 20 of a period -> current period keeps 15/50; next period has P=250 with 125 high cycles.
5. Polarity and en: ch_pol[0]=1, en=0 -> pwm_out[0]=1 and period_count held; on en rise, period_start pulses in the first cycle and the inverted waveform begins.
6. Reset mid-period (rstn low for 3 cycles at cnt=17) -> all outputs 0 asynchronously; after release the shadows are 0 and outputs stay 0 until en=1.
